// File: rtl/conv2d_window_sched.sv
// Valid-mode 3x3 convolution sequencer: fetches each window from the input memory,
// hands it to a shared MAC and writes the 16-bit result to the output memory.
module conv2d_window_sched #(
  parameter int ADDR_W  = 16,
  parameter int OADDR_W = 16,
  parameter int DIM_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   img_w,
  input  logic [DIM_W-1:0]   img_h,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [7:0]         mem_rd_data,
  output logic               acc_valid_in,
  output logic [71:0]        acc_win,
  input  logic               acc_valid_out,
  input  logic [15:0]        acc_result,
  output logic               out_wr_en,
  output logic [OADDR_W-1:0] out_wr_addr,
  output logic [15:0]        out_wr_data
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | nine reads of the current window
  // DRAIN  | capture of the last pixel
  // ISSUE  | window presented to the MAC
  // WAIT   | waiting for the MAC result, bounded by the timeout timer
  // WRITE  | result written, position advanced
  // FIN    | done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_ISSUE, S_WAIT, S_WRITE, S_FIN
  } state_t;

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   w_q, h_q, r_q, c_q;
  logic [1:0]         kr_q, kc_q;
  logic               cap_en_q;
  logic [3:0]         cap_idx_q;
  logic [71:0]        win_q;
  logic [15:0]        res_q;
  logic [TMR_W-1:0]   tmr_q;
  logic               err_q;

  logic dims_ok, fetch_last, col_last, row_last, tmr_tc;

  assign dims_ok    = (img_w >= DIM_W'(3)) && (img_h >= DIM_W'(3));
  assign fetch_last = (kr_q == 2'd2) && (kc_q == 2'd2);
  assign col_last   = (c_q == w_q - DIM_W'(3));
  assign row_last   = (r_q == h_q - DIM_W'(3));
  assign tmr_tc     = (tmr_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = dims_ok ? S_FETCH : S_FIN;
      S_FETCH: if (fetch_last) state_d = S_DRAIN;
      S_DRAIN: state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (acc_valid_out)  state_d = S_WRITE;
        else if (tmr_tc)    state_d = S_FIN;
      end
      S_WRITE: state_d = (col_last && row_last) ? S_FIN : S_FETCH;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q       <= '0;
      h_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      kr_q      <= '0;
      kc_q      <= '0;
      cap_en_q  <= 1'b0;
      cap_idx_q <= '0;
      win_q     <= '0;
      res_q     <= '0;
      tmr_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      // Read data lags the strobe by one cycle, so the slot index is delayed with it.
      cap_en_q  <= (state_q == S_FETCH);
      cap_idx_q <= 4'(kr_q) * 4'd3 + 4'(kc_q);
      if (cap_en_q) win_q[{cap_idx_q, 3'b000} +: 8] <= mem_rd_data;

      case (state_q)
        S_IDLE: begin
          if (start && dims_ok) begin
            w_q   <= img_w;
            h_q   <= img_h;
            r_q   <= '0;
            c_q   <= '0;
            kr_q  <= '0;
            kc_q  <= '0;
            err_q <= 1'b0;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (kc_q == 2'd2) begin
            kc_q <= '0;
            kr_q <= (kr_q == 2'd2) ? 2'd0 : kr_q + 2'd1;
          end else begin
            kc_q <= kc_q + 2'd1;
          end
        end
        S_ISSUE: tmr_q <= TMR_W'(TIMEOUT - 1);
        S_WAIT: begin
          if (acc_valid_out)  res_q <= acc_result;
          else if (!tmr_tc)   tmr_q <= tmr_q - TMR_W'(1);
          else                err_q <= 1'b1;
        end
        S_WRITE: begin
          if (col_last) begin
            c_q <= '0;
            r_q <= r_q + DIM_W'(1);
          end else begin
            c_q <= c_q + DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done         = (state_q == S_FIN);
  assign err          = err_q;
  assign mem_rd_en    = (state_q == S_FETCH);
  assign mem_rd_addr  = (state_q == S_FETCH) ?
                        ADDR_W'((32'(r_q) + 32'(kr_q)) * 32'(w_q) + 32'(c_q) + 32'(kc_q)) : '0;
  assign acc_valid_in = (state_q == S_ISSUE);
  assign acc_win      = win_q;
  assign out_wr_en    = (state_q == S_WRITE);
  assign out_wr_addr  = (state_q == S_WRITE) ?
                        OADDR_W'(32'(r_q) * (32'(w_q) - 32'd2) + 32'(c_q)) : '0;
  assign out_wr_data  = (state_q == S_WRITE) ? res_q : '0;

endmodule

// File: tb/tb_conv2d_window_sched.sv
// Scoreboard bench for conv2d_window_sched with a behavioural memory and a
// variable-latency MAC model; expectations come from direct 3x3 arithmetic.
module tb_conv2d_window_sched;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  img_w, img_h;
  logic        busy, done, err;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic        acc_valid_in;
  logic [71:0] acc_win;
  logic        acc_valid_out;
  logic [15:0] acc_result;
  logic        out_wr_en;
  logic [15:0] out_wr_addr, out_wr_data;

  always #5 clk = ~clk;

  conv2d_window_sched #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
    .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .acc_valid_in(acc_valid_in), .acc_win(acc_win),
    .acc_valid_out(acc_valid_out), .acc_result(acc_result),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
  );

  int wt [9] = '{3, -2, 1, 5, -4, 2, -1, 7, -3};
  logic signed [7:0] mem [0:255];

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[7:0]];

  function automatic logic [15:0] mac_fn(input logic [71:0] win);
    int s = 0;
    for (int k = 0; k < 9; k++) s += wt[k] * int'($signed(win[k*8 +: 8]));
    return 16'(s);
  endfunction

  int mac_lat = 1;
  bit mac_dead = 0;
  bit mac_force = 0;
  logic [15:0] pd [0:7];
  logic        pv [0:7];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
    end else begin
      pv[0] <= acc_valid_in && !mac_dead;
      pd[0] <= mac_force ? 16'hFED4 : mac_fn(acc_win);
      for (int i = 1; i < 8; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
    end
  end
  assign acc_valid_out = pv[mac_lat-1];
  assign acc_result    = pd[mac_lat-1];

  int errors = 0, checks = 0;
  typedef struct { int addr; int data; } wr_t;
  int  exp_rd [$];
  wr_t exp_wr [$];
  int  wr_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got strobe expected none", name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) begin
        if (exp_rd.size() == 0) fail_now("unexpected_read");
        else check("rd_addr", int'(mem_rd_addr), exp_rd.pop_front());
      end
      if (out_wr_en) begin
        wr_t e;
        wr_seen++;
        if (exp_wr.size() == 0) fail_now("unexpected_write");
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", int'(out_wr_addr), e.addr);
          check("wr_data", int'(out_wr_data), e.data & 32'hFFFF);
        end
      end
      if (mem_rd_en || acc_valid_in || out_wr_en)
        check("strobe_excl", int'(mem_rd_en) + int'(acc_valid_in) + int'(out_wr_en), 1);
    end
  end

  function automatic int ref_px(input int r, input int c, input int w);
    int s = 0;
    for (int k = 0; k < 9; k++) s += wt[k] * int'(mem[(r + k/3) * w + c + k%3]);
    return s;
  endfunction

  task automatic push_window(input int r, input int c, input int w);
    for (int k = 0; k < 9; k++) exp_rd.push_back((r + k/3) * w + c + k%3);
  endtask

  task automatic run_job(input int w, input int h, input bit glitch);
    int n, exp_cyc, cyc, nwr;
    bit ok;
    wr_t e;
    ok = (w >= 3) && (h >= 3);
    n  = ok ? (w - 2) * (h - 2) : 0;
    if (ok && mac_dead) begin
      push_window(0, 0, w);
      nwr = 0;
      exp_cyc = 1 + 11 + TIMEOUT;
    end else begin
      for (int r = 0; r < h - 2; r++)
        for (int c = 0; c < w - 2; c++) begin
          push_window(r, c, w);
          e.addr = r * (w - 2) + c;
          e.data = mac_force ? -300 : ref_px(r, c, w);
          exp_wr.push_back(e);
        end
      nwr = n;
      exp_cyc = ok ? 1 + n * (12 + mac_lat) : 1;
    end
    wr_seen = 0;
    @(negedge clk);
    img_w = 8'(w); img_h = 8'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", int'(busy), ok ? 1 : 0);
    check("err_after_start", int'(err), ok ? 0 : 1);
    while (done !== 1'b1 && cyc < exp_cyc + 60) begin
      if (glitch && cyc == 5) begin
        start = 1'b1;
        img_w = 8'($urandom_range(0, 9));
        img_h = 8'($urandom_range(0, 9));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_cycle", cyc, exp_cyc);
    check("err_at_done", int'(err), (!ok || mac_dead) ? 1 : 0);
    check("write_count", wr_seen, nwr);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    check("rd_left", exp_rd.size(), 0);
    check("wr_left", exp_wr.size(), 0);
    exp_rd.delete();
    exp_wr.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; img_w = '0; img_h = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_win_zero", (acc_win == '0) ? 1 : 0, 1);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) mem[i] = (i < 9) ? 8'(i + 1) : 8'h00;
    mac_lat = 1;
    run_job(3, 3, 0);

    fill_random();
    run_job(5, 4, 0);

    mac_force = 1;
    run_job(3, 3, 0);
    mac_force = 0;

    run_job(2, 8, 0);

    mac_dead = 1;
    run_job(3, 3, 0);
    mac_dead = 0;
    run_job(3, 3, 0);

    fill_random();
    run_job(5, 4, 1);

    // Abandon a job while it sits waiting on a silent MAC.
    mac_dead = 1;
    push_window(0, 0, 5);
    wr_seen = 0;
    @(negedge clk);
    img_w = 8'd5; img_h = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      if (acc_valid_in) seen = 1;
      @(negedge clk);
    end
    check("issue_seen", seen, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    check("rst_mid_err", int'(err), 0);
    check("rst_mid_rd", int'(mem_rd_en) + int'(mem_rd_addr), 0);
    check("rst_mid_issue", int'(acc_valid_in), 0);
    check("rst_mid_win_zero", (acc_win == '0) ? 1 : 0, 1);
    check("rst_mid_wr", int'(out_wr_en) + int'(out_wr_addr) + int'(out_wr_data), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    mac_dead = 0;
    repeat (40) @(negedge clk);
    check("writes_after_rst", wr_seen, 0);
    check("idle_after_rst", int'(busy), 0);
    run_job(4, 3, 0);

    for (int j = 0; j < 10; j++) begin
      fill_random();
      mac_lat = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0)
        run_job($urandom_range(0, 2), $urandom_range(0, 9), 0);
      else
        run_job($urandom_range(3, 8), $urandom_range(3, 6), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
